// File: rtl/ram_arb.sv
// ram_arb: two-requester arbiter in front of one single-port RAM (instruction or data RAM).
//
// Requester 0 is the UART debug loader and requester 1 is the CPU load/store path. They share
// the RAM port through a req/gnt handshake. An access completes on any cycle where req & gnt.
// Read data from the RAM arrives one cycle after the address. It is returned to the requester
// that issued the read, even if ownership has changed in the meantime.
//
// Optional feature: define RAM_ARB_STATS_EN to build the saturating conflict counter on
// stat_conflict_o. When it is not defined, stat_conflict_o is tied to zero.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   dbg_lock_i            requester 0 gets exclusive ownership; requester 1 is never granted
//   mX_req_i / mX_we_i    requester X access request / write (1) or read (0)
//   mX_addr_i             requester X byte address
//   mX_wdata_i            requester X write data
//   mX_byte_en_i          requester X write byte enables
//   mX_gnt_o              requester X access accepted this cycle
//   mX_rvld_o/mX_rdata_o  requester X read data valid / read data (held until next rvld)
//   ram_rd_addr_o         RAM read address (holds last read address while idle)
//   ram_wr_addr_o         RAM write address (holds last write address while idle)
//   ram_wr_data_o         RAM write data (holds last write data while idle)
//   ram_wr_byte_en_o      RAM byte write enables (zero unless a write is granted)
//   ram_rd_data_i         RAM read data, valid one cycle after the read address
//   stat_conflict_o       number of cycles in which both requesters were requesting

module ram_arb #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dbg_lock_i,

    input  logic            m0_req_i,
    input  logic            m0_we_i,
    input  logic [XLEN-1:0] m0_addr_i,
    input  logic [XLEN-1:0] m0_wdata_i,
    input  logic [3:0]      m0_byte_en_i,
    output logic            m0_gnt_o,
    output logic            m0_rvld_o,
    output logic [XLEN-1:0] m0_rdata_o,

    input  logic            m1_req_i,
    input  logic            m1_we_i,
    input  logic [XLEN-1:0] m1_addr_i,
    input  logic [XLEN-1:0] m1_wdata_i,
    input  logic [3:0]      m1_byte_en_i,
    output logic            m1_gnt_o,
    output logic            m1_rvld_o,
    output logic [XLEN-1:0] m1_rdata_o,

    output logic [XLEN-1:0] ram_rd_addr_o,
    output logic [XLEN-1:0] ram_wr_addr_o,
    output logic [XLEN-1:0] ram_wr_data_o,
    output logic [3:0]      ram_wr_byte_en_o,
    input  logic [XLEN-1:0] ram_rd_data_i,

    output logic [XLEN-1:0] stat_conflict_o
);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    // Last burst slot before a forced hand-over to a waiting requester.
    localparam logic [7:0] BurstLast = 8'(BURST_MAX - 1);

    state_e          state_q;
    logic            last_owner_q;
    logic [7:0]      burst_cnt_q;

    logic            gnt0;
    logic            gnt1;
    logic            acc_vld;
    logic            acc_we;
    logic [XLEN-1:0] acc_addr;
    logic [XLEN-1:0] acc_wdata;
    logic [3:0]      acc_byte_en;

    logic [XLEN-1:0] rd_addr_q;
    logic [XLEN-1:0] wr_addr_q;
    logic [XLEN-1:0] wr_data_q;
    logic            m0_rvld_q;
    logic            m1_rvld_q;
    logic [XLEN-1:0] m0_rdata_q;
    logic [XLEN-1:0] m1_rdata_q;

    // ------------------------------------------------------------------
    // Grants come straight from the ownership state. Masking by rst_i keeps an access from
    // completing in a reset cycle. Masking by dbg_lock_i blocks m1 in the cycle the lock rises.
    // ------------------------------------------------------------------
    assign gnt0 = (state_q == StOwn0) && m0_req_i && !rst_i;
    assign gnt1 = (state_q == StOwn1) && m1_req_i && !dbg_lock_i && !rst_i;

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    // Select the granted requester's access. At most one grant is active.
    always_comb begin
        acc_vld     = 1'b0;
        acc_we      = 1'b0;
        acc_addr    = '0;
        acc_wdata   = '0;
        acc_byte_en = '0;
        if (gnt0) begin
            acc_vld     = 1'b1;
            acc_we      = m0_we_i;
            acc_addr    = m0_addr_i;
            acc_wdata   = m0_wdata_i;
            acc_byte_en = m0_byte_en_i;
        end else if (gnt1) begin
            acc_vld     = 1'b1;
            acc_we      = m1_we_i;
            acc_addr    = m1_addr_i;
            acc_wdata   = m1_wdata_i;
            acc_byte_en = m1_byte_en_i;
        end
    end

    // RAM side: pass the granted access through combinationally and hold otherwise.
    always_comb begin
        ram_rd_addr_o    = rd_addr_q;
        ram_wr_addr_o    = wr_addr_q;
        ram_wr_data_o    = wr_data_q;
        ram_wr_byte_en_o = '0;
        if (acc_vld) begin
            if (acc_we) begin
                ram_wr_addr_o    = acc_addr;
                ram_wr_data_o    = acc_wdata;
                ram_wr_byte_en_o = acc_byte_en;
            end else begin
                ram_rd_addr_o    = acc_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Ownership FSM with round-robin tie-break and burst limiting
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    burst_cnt_q <= '0;
                    if (dbg_lock_i) begin
                        state_q      <= StOwn0;
                        last_owner_q <= 1'b0;
                    end else if (m0_req_i && (!m1_req_i || last_owner_q)) begin
                        state_q      <= StOwn0;
                        last_owner_q <= 1'b0;
                    end else if (m1_req_i) begin
                        state_q      <= StOwn1;
                        last_owner_q <= 1'b1;
                    end
                end
                StOwn0: begin
                    if (!m0_req_i) begin
                        state_q     <= StIdle;
                        burst_cnt_q <= '0;
                    end else if (!m1_req_i) begin
                        burst_cnt_q <= '0;
                    end else if (burst_cnt_q == BurstLast) begin
                        // Under lock m0 keeps the port and the count saturates.
                        if (!dbg_lock_i) begin
                            state_q      <= StOwn1;
                            last_owner_q <= 1'b1;
                            burst_cnt_q  <= '0;
                        end
                    end else begin
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                    end
                end
                StOwn1: begin
                    if (dbg_lock_i) begin
                        state_q      <= StOwn0;
                        last_owner_q <= 1'b0;
                        burst_cnt_q  <= '0;
                    end else if (!m1_req_i) begin
                        state_q     <= StIdle;
                        burst_cnt_q <= '0;
                    end else if (!m0_req_i) begin
                        burst_cnt_q <= '0;
                    end else if (burst_cnt_q == BurstLast) begin
                        state_q      <= StOwn0;
                        last_owner_q <= 1'b0;
                        burst_cnt_q  <= '0;
                    end else begin
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    burst_cnt_q <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Held RAM addresses/data and read-return tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            m0_rvld_q  <= 1'b0;
            m1_rvld_q  <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (acc_vld && acc_we) begin
                wr_addr_q <= acc_addr;
                wr_data_q <= acc_wdata;
            end
            if (acc_vld && !acc_we) begin
                rd_addr_q <= acc_addr;
            end
            // The tag goes with the requester that issued the read, not with the current owner.
            m0_rvld_q <= gnt0 && !m0_we_i;
            m1_rvld_q <= gnt1 && !m1_we_i;
            if (m0_rvld_q) begin
                m0_rdata_q <= ram_rd_data_i;
            end
            if (m1_rvld_q) begin
                m1_rdata_q <= ram_rd_data_i;
            end
        end
    end

    // A read-return that lines up with a reset cycle is dropped.
    assign m0_rvld_o = m0_rvld_q && !rst_i;
    assign m1_rvld_o = m1_rvld_q && !rst_i;

    // In the rvld cycle the RAM data passes straight through. Afterwards the captured copy
    // holds until the next rvld.
    assign m0_rdata_o = m0_rvld_o ? ram_rd_data_i : m0_rdata_q;
    assign m1_rdata_o = m1_rvld_o ? ram_rd_data_i : m1_rdata_q;

    // ------------------------------------------------------------------
    // Conflict statistics
    // ------------------------------------------------------------------
`ifdef RAM_ARB_STATS_EN
    logic [XLEN-1:0] stat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_q <= '0;
        end else if (m0_req_i && m1_req_i && (stat_q != '1)) begin
            stat_q <= stat_q + XLEN'(1);
        end
    end

    assign stat_conflict_o = stat_q;
`else
    assign stat_conflict_o = '0;
`endif

endmodule
